// File: rtl/gamefile_interface.sv
// rtl/gamefile_interface.sv - Avalon-MM shadow/active gamefile store with vsync-aligned commit
module gamefile_interface #(
    parameter int NUM_WORDS = 64,
    parameter int FCNT_W    = 16
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      AVL_CS,
    input  logic                      AVL_READ,
    input  logic                      AVL_WRITE,
    input  logic [6:0]                AVL_ADDR,
    input  logic [3:0]                AVL_BYTE_EN,
    input  logic [31:0]               AVL_WRITEDATA,
    output logic [31:0]               AVL_READDATA,
    input  logic                      VGA_VS,
    output logic [32*NUM_WORDS-1:0]   gamefile,
    output logic                      commit_pulse,
    output logic                      commit_pending
);
    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [6:0] ADDR_CTRL   = 7'd64;
    localparam logic [6:0] ADDR_IDX    = 7'd65;
    localparam logic [6:0] ADDR_MIRROR = 7'd66;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    logic [NUM_WORDS-1:0][31:0] shadow_q, shadow_d;
    logic [NUM_WORDS-1:0][31:0] active_q, active_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [FCNT_W-1:0]          fcnt_q, fcnt_d;
    logic [5:0]                 idx_q, idx_d;
    logic [0:0]                 state_q, state_d;
    logic                       pulse_q;
    logic                       vs_s1_q, vs_s2_q, vs_s3_q;

    logic          word_sel;
    logic [IW-1:0] word_idx;
    logic          ctrl_wr, commit_now, arm_req, vs_fall, do_commit;

    assign word_sel   = (AVL_ADDR < 7'(NUM_WORDS));
    assign word_idx   = AVL_ADDR[IW-1:0];
    assign ctrl_wr    = AVL_CS && AVL_WRITE && (AVL_ADDR == ADDR_CTRL);
    assign commit_now = ctrl_wr && AVL_WRITEDATA[1];
    assign arm_req    = ctrl_wr && AVL_WRITEDATA[0] && !AVL_WRITEDATA[1];
    assign vs_fall    = vs_s3_q && !vs_s2_q;
    assign do_commit  = commit_now || ((state_q == ST_ARMED) && vs_fall);

    always_comb begin
        shadow_d = shadow_q;
        if (AVL_CS && AVL_WRITE && word_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (AVL_BYTE_EN[b]) shadow_d[word_idx][8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
            end
        end
    end

    // The commit copies shadow_q, so a same-cycle shadow write lands only on a later commit.
    always_comb begin
        active_d = do_commit ? shadow_q : active_q;
        fcnt_d   = do_commit ? fcnt_q + 1'b1 : fcnt_q;
        idx_d    = (AVL_CS && AVL_WRITE && (AVL_ADDR == ADDR_IDX)) ? AVL_WRITEDATA[5:0] : idx_q;
        state_d  = state_q;
        if (do_commit)    state_d = ST_IDLE;
        else if (arm_req) state_d = ST_ARMED;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (AVL_CS && AVL_READ) begin
            rdata_d = '0;
            if (word_sel) begin
                rdata_d = shadow_q[word_idx];
            end else begin
                case (AVL_ADDR)
                    ADDR_CTRL: begin
                        rdata_d[FCNT_W-1:0] = fcnt_q;
                        rdata_d[FCNT_W]     = state_q[0];
                    end
                    ADDR_IDX:    rdata_d[5:0] = idx_q;
                    ADDR_MIRROR: rdata_d = active_q[idx_q];
                    default:     rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow_q <= '0;
            active_q <= '0;
            rdata_q  <= '0;
            fcnt_q   <= '0;
            idx_q    <= '0;
            state_q  <= ST_IDLE;
            pulse_q  <= 1'b0;
            vs_s1_q  <= 1'b1;
            vs_s2_q  <= 1'b1;
            vs_s3_q  <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            rdata_q  <= rdata_d;
            fcnt_q   <= fcnt_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            pulse_q  <= do_commit;
            vs_s1_q  <= VGA_VS;
            vs_s2_q  <= vs_s1_q;
            vs_s3_q  <= vs_s2_q;
        end
    end

    assign gamefile       = active_q;
    assign AVL_READDATA   = rdata_q;
    assign commit_pulse   = pulse_q;
    assign commit_pending = (state_q == ST_ARMED);
endmodule

// File: tb/tb_gamefile_interface.sv
// tb/tb_gamefile_interface.sv - directed self-checking bench for gamefile_interface
`timescale 1ns/1ps
module tb_gamefile_interface;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [6:0]    addr = '0;
    logic [3:0]    be = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          vs = 1'b1;
    logic [2047:0] gf;
    logic          pulse, pending;

    int checks = 0;
    int errors = 0;
    logic [31:0]   r;
    logic [2047:0] exp_gf;

    gamefile_interface dut (
        .CLK(clk), .RESET_N(rst_n), .AVL_CS(cs), .AVL_READ(rd), .AVL_WRITE(wr),
        .AVL_ADDR(addr), .AVL_BYTE_EN(be), .AVL_WRITEDATA(wdata), .AVL_READDATA(rdata),
        .VGA_VS(vs), .gamefile(gf), .commit_pulse(pulse), .commit_pending(pending)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic chk_gf(input string tag, input logic [2047:0] exp);
        int bad;
        bad = -1;
        for (int k = 63; k >= 0; k--) if (gf[32*k +: 32] !== exp[32*k +: 32]) bad = k;
        checks++;
        assert (bad < 0) else begin
            errors++;
            $error("FAIL %s word %0d got %08h exp %08h", tag, bad, gf[32*bad +: 32], exp[32*bad +: 32]);
        end
    endtask

    task automatic avl_wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic avl_rd(input logic [6:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
        d = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_gf("reset_gamefile", '0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_pulse", 32'(pulse), 32'd0);
        chk("reset_readdata", rdata, 32'd0);

        // Reset mid-frame
        avl_wr(7'd5, 32'h12345678, 4'hF);
        avl_wr(7'd64, 32'd2, 4'hF);
        chk("imm_pulse", 32'(pulse), 32'd1);
        chk("imm_word5", gf[32*5 +: 32], 32'h12345678);
        avl_wr(7'd64, 32'd1, 4'hF);
        chk("armed_pending", 32'(pending), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_gf("async_reset_gamefile", '0);
        chk("async_reset_pending", 32'(pending), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        avl_rd(7'd64, r); chk("reset_ctrl", r, 32'd0);
        avl_rd(7'd5, r);  chk("reset_word5", r, 32'd0);

        // Byte enables
        avl_wr(7'd3, 32'hAABBCCDD, 4'b1111);
        avl_wr(7'd3, 32'h11223344, 4'b0101);
        avl_rd(7'd3, r); chk("byte_en", r, 32'hAA22CC44);

        // Deferred commit
        exp_gf = '0;
        for (int k = 0; k < 64; k++) begin
            avl_wr(7'(k), 32'(k), 4'hF);
            exp_gf[32*k +: 32] = 32'(k);
        end
        avl_wr(7'd64, 32'd1, 4'hF);
        chk("defer_pending", 32'(pending), 32'd1);
        repeat (20) @(negedge clk);
        vs = 1'b0;
        @(posedge clk); #1;
        chk_gf("defer_after_e0", '0);
        @(posedge clk); #1;
        chk_gf("defer_after_e1", '0);
        chk("defer_pulse_e1", 32'(pulse), 32'd0);
        @(posedge clk); #1;
        chk_gf("defer_after_e2", exp_gf);
        chk("defer_pulse_e2", 32'(pulse), 32'd1);
        chk("defer_pending_e2", 32'(pending), 32'd0);
        @(posedge clk); #1;
        chk("defer_pulse_e3", 32'(pulse), 32'd0);
        repeat (3) @(negedge clk);
        vs = 1'b1;
        avl_rd(7'd64, r); chk("defer_ctrl", r, 32'h00000001);

        // vsync while idle does nothing
        repeat (5) @(negedge clk);
        vs = 1'b0;
        repeat (6) @(negedge clk);
        vs = 1'b1;
        repeat (5) @(negedge clk);
        avl_rd(7'd64, r); chk("idle_vsync_ctrl", r, 32'h00000001);
        chk_gf("idle_vsync_gamefile", exp_gf);

        // Collision: shadow write on the commit edge
        avl_wr(7'd64, 32'd1, 4'hF);
        @(negedge clk);
        vs = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = 7'd0; wdata = 32'h0000FFFF; be = 4'hF;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
        chk("collide_pulse", 32'(pulse), 32'd1);
        chk("collide_word0", gf[31:0], 32'd0);
        repeat (3) @(negedge clk);
        vs = 1'b1;
        avl_wr(7'd65, 32'd0, 4'hF);
        avl_rd(7'd65, r); chk("collide_idx", r, 32'd0);
        avl_rd(7'd66, r); chk("collide_mirror_old", r, 32'd0);
        avl_rd(7'd0, r);  chk("collide_shadow0", r, 32'h0000FFFF);
        avl_wr(7'd64, 32'd2, 4'hF);
        avl_rd(7'd66, r); chk("collide_mirror_new", r, 32'h0000FFFF);
        avl_wr(7'd65, 32'd9, 4'hF);
        avl_rd(7'd66, r); chk("mirror_word9", r, 32'd9);

        // Override while armed
        repeat (5) @(negedge clk);
        avl_wr(7'd64, 32'd1, 4'hF);
        avl_wr(7'd5, 32'hCAFE0005, 4'hF);
        avl_wr(7'd64, 32'd3, 4'hF);
        chk("override_pulse", 32'(pulse), 32'd1);
        chk("override_pending", 32'(pending), 32'd0);
        chk("override_word5", gf[32*5 +: 32], 32'hCAFE0005);
        avl_rd(7'd64, r); chk("override_ctrl", r, 32'h00000004);

        // Unmapped addresses
        avl_wr(7'd70, 32'hDEADBEEF, 4'hF);
        avl_rd(7'd70, r); chk("unmapped_70", r, 32'd0);
        avl_rd(7'd67, r); chk("unmapped_67", r, 32'd0);

        // FCNT wrap
        do_reset();
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = 7'd64; wdata = 32'd2; be = 4'hF;
        repeat (65535) @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
        avl_rd(7'd64, r); chk("fcnt_max", r, 32'h0000FFFF);
        avl_wr(7'd64, 32'd2, 4'hF);
        avl_rd(7'd64, r); chk("fcnt_wrap", r, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gamefile_interface.md
# gamefile_interface

Avalon-MM slave that owns the 2048-bit `gamefile` consumed by the on-chip field decoder and sprite/background renderers. Software (NIOS II) writes 64 × 32-bit words into a shadow buffer, then requests a commit. The block copies the shadow buffer into the active `gamefile` only at the start of vertical sync, so the renderers never see a half-updated frame. It also provides readback, commit status and a frame counter.

## Interface
Parameters:
- `NUM_WORDS`, 64: shadow/active words; `gamefile` width = 32·NUM_WORDS.
- `FCNT_W`, 16: frame counter width.

Ports:
- `CLK` in 1: system clock (50 MHz).
- `RESET_N` in 1: asynchronous, active-low reset.
- `AVL_CS` in 1: chip select.
- `AVL_READ` in 1: read strobe.
- `AVL_WRITE` in 1: write strobe.
- `AVL_ADDR` in 7: word address.
- `AVL_BYTE_EN` in 4: byte enables for writes.
- `AVL_WRITEDATA` in 32: write data.
- `AVL_READDATA` out 32: read data, registered, read latency 1.
- `VGA_VS` in 1: raw active-low vertical sync from the VGA controller, asynchronous to CLK.
- `gamefile` out 2048: active frame description; word k occupies bits [32k+31:32k].
- `commit_pulse` out 1: one-cycle strobe on the cycle `gamefile` is loaded.
- `commit_pending` out 1: commit requested, not yet applied.

## Operation
- Address map:
  - 0–63: shadow words, R/W.
  - 64: CTRL. Write bit0 = request commit at next vsync; bit1 = commit immediately. Read = {15'b0, pending, FCNT}.
  - 65: active-word index register, R/W, 6 bits.
  - 66: read-only mirror of the active word selected by addr 65.
  - 67–127: writes ignored, reads return 0.
- Shadow writes occur when AVL_CS & AVL_WRITE on addr < 64. Each byte lane is updated only when its AVL_BYTE_EN bit is 1.
- Reads: when AVL_CS & AVL_READ, AVL_READDATA is loaded at the next edge. Otherwise AVL_READDATA holds its value.
- Vsync detect:
  - VGA_VS passes through a 3-flop chain s1→s2→s3; all three flops reset to 1.
  - `vs_fall` = s3 & ~s2.
- Commit state (pending flag; IDLE = 0, ARMED = 1):
  - IDLE → ARMED on a CTRL write with bit0 = 1 and bit1 = 0.
  - ARMED → IDLE on `vs_fall`. At that edge: `gamefile` ← shadow, `commit_pulse` = 1, FCNT += 1.
  - Any state → IDLE on a CTRL write with bit1 = 1. At that edge: `gamefile` ← shadow, `commit_pulse` = 1, FCNT += 1. bit1 overrides bit0.
  - bit0 written while ARMED: no change.
  - CTRL write of 0: no change (no cancel).
- Simultaneous events:
  - Shadow write on the commit edge: the commit copies the pre-write shadow. The new data reaches `gamefile` only on a later commit.
  - CTRL bit0 write on a `vs_fall` cycle while IDLE: goes to ARMED and waits for the next `vs_fall`.
  - `vs_fall` while IDLE: no action.
- FCNT is FCNT_W bits and wraps from 0xFFFF to 0 without a flag.
- Reset, asserted at any time: shadow, `gamefile`, AVL_READDATA, FCNT, index register, pending and `commit_pulse` all go to 0. Sync flops go to 1. An in-flight commit is discarded.

## Timing
- Shadow write: visible to a read issued on the next cycle.
- Read: AVL_READDATA is valid one CLK after the read cycle (readLatency = 1, no waitrequest).
- Vsync commit:
  - Let edge E0 be where s1 first captures VGA_VS = 0.
  - `vs_fall` is high during the cycle after E1.
  - `gamefile` and FCNT update at E2, and `commit_pulse` is high for that one cycle.
- Immediate commit: `gamefile` updates at the same edge that accepts the CTRL write.
- `commit_pending` equals the pending flag directly, with no extra latency.
- VGA_VS low pulses must last at least 3 CLK cycles. The 640×480 vsync of 2 lines meets this.

## Test plan
- Reset mid-frame:
  - Stimulus: write word 5 = 0x12345678, arm a commit, assert RESET_N low for 2 cycles.
  - Required: `gamefile` = 0, FCNT = 0, pending = 0, and reading addr 5 returns 0.
- Byte enables:
  - Stimulus: write addr 3 with 0xAABBCCDD and BYTE_EN = 4'b1111, then 0x11223344 with BYTE_EN = 4'b0101.
  - Required: readback = 0xAA22CC44.
- Deferred commit:
  - Stimulus: write words 0..63 = k, CTRL = 1, drive VGA_VS low at cycle 100.
  - Required: `gamefile` stays 0 until 2 edges after the first low sample. Then `gamefile[32k+31:32k]` = k, `commit_pulse` is high for exactly 1 cycle, and CTRL reads 0x00000001.
- Collision:
  - Stimulus: shadow write of word 0 = 0xFFFF on the commit edge.
  - Required: active word 0 keeps its old value, and addr 65 = 0 / addr 66 readback confirms it. A second immediate commit (CTRL = 2) makes it 0xFFFF.
- Override and wrap:
  - Stimulus: CTRL = 3 while ARMED.
  - Required: immediate load and pending = 0.
  - Stimulus: preload FCNT to 0xFFFF via 65535 immediate commits, then one more.
  - Required: FCNT = 0.
